fir_engine_ctrl: RTL and testbench

//  Sequencer for the 11-tap FIR datapath: owns the tap and data BRAM ports while running, keeps the data

---
 rtl/fir_engine_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_fir_engine_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_engine_ctrl.sv
// fir_engine_ctrl: sequencer for the 11-tap FIR datapath.
// Owns the tap and data BRAM ports while a run is active, keeps the data BRAM
// as a circular sample buffer (head = newest sample), performs one MAC pass per
// accepted input sample and streams each result out on the master AXI-Stream.
// Status and stream outputs are registers. The BRAM ports are a decode of the
// registered state because the sample write has to land in the handshake
// cycle so that the first MAC read of the same index sees the new sample.

module fir_engine_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   len_err,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do
);

    // Index width also covers the value Tape_Num, used as the MAC drain step.
    localparam int               IDX_W    = $clog2(Tape_Num + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Tape_Num - 1);
    localparam logic [IDX_W-1:0] DRAIN_K  = IDX_W'(Tape_Num);
    localparam logic [IDX_W:0]   TAPS_EXT = (IDX_W + 1)'(Tape_Num);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_MAC     = 3'd3,
        ST_OUT     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Byte address of a BRAM word index (word = 4 bytes).
    function automatic logic [pADDR_WIDTH-1:0] idx_to_addr(input logic [IDX_W-1:0] idx);
        logic [pADDR_WIDTH-1:0] addr;
        addr = '0;
        addr[IDX_W+1:2] = idx;
        return addr;
    endfunction

    // (base - back) mod Tape_Num, for base/back in 0..Tape_Num-1.
    function automatic logic [IDX_W-1:0] circ_idx(input logic [IDX_W-1:0] base,
                                                   input logic [IDX_W-1:0] back);
        logic [IDX_W:0] sum;
        if (base >= back) begin
            sum = {1'b0, base} - {1'b0, back};
        end else begin
            sum = {1'b0, base} + TAPS_EXT - {1'b0, back};
        end
        return sum[IDX_W-1:0];
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [IDX_W-1:0]       k_r, k_nxt_s;
    logic [IDX_W-1:0]       head_r, head_nxt_s;
    logic [31:0]            count_r, count_nxt_s;
    logic [pDATA_WIDTH-1:0] acc_r, acc_nxt_s;
    logic                   ap_idle_r, ap_idle_nxt_s;
    logic                   ap_done_r, ap_done_nxt_s;
    logic                   len_err_r, len_err_nxt_s;
    logic                   ss_tready_r, ss_tready_nxt_s;
    logic                   sm_tvalid_r, sm_tvalid_nxt_s;
    logic [pDATA_WIDTH-1:0] sm_tdata_r, sm_tdata_nxt_s;
    logic                   sm_tlast_r, sm_tlast_nxt_s;

    logic                   tap_en_s;
    logic [pADDR_WIDTH-1:0] tap_a_s;
    logic [3:0]             data_we_s;
    logic                   data_en_s;
    logic [pADDR_WIDTH-1:0] data_a_s;
    logic [pDATA_WIDTH-1:0] data_di_s;

    logic                   in_hs_s;
    logic [31:0]            count_inc_s;
    logic [pDATA_WIDTH-1:0] prod_lo_s;
    logic [pDATA_WIDTH-1:0] acc_add_s;

    assign in_hs_s     = ss_tvalid & ss_tready_r;
    assign count_inc_s = count_r + 32'd1;
    // Low word of a two's-complement product is the same for signed and
    // unsigned operands, so a plain same-width multiply gives the signed result.
    assign prod_lo_s   = tap_Do * data_Do;
    assign acc_add_s   = acc_r + prod_lo_s;

    // Next-state, next-register values and BRAM port decode.
    always_comb begin
        state_nxt_s     = state_r;
        k_nxt_s         = k_r;
        head_nxt_s      = head_r;
        count_nxt_s     = count_r;
        acc_nxt_s       = acc_r;
        ap_idle_nxt_s   = ap_idle_r;
        ap_done_nxt_s   = ap_done_r;
        len_err_nxt_s   = len_err_r;
        ss_tready_nxt_s = ss_tready_r;
        sm_tvalid_nxt_s = sm_tvalid_r;
        sm_tdata_nxt_s  = sm_tdata_r;
        sm_tlast_nxt_s  = sm_tlast_r;
        tap_en_s        = 1'b0;
        tap_a_s         = '0;
        data_we_s       = 4'h0;
        data_en_s       = 1'b0;
        data_a_s        = '0;
        data_di_s       = '0;

        case (state_r)
            ST_IDLE: begin
                if (ap_start) begin
                    state_nxt_s   = ST_CLEAR;
                    ap_idle_nxt_s = 1'b0;
                    ap_done_nxt_s = 1'b0;
                    len_err_nxt_s = 1'b0;
                    count_nxt_s   = 32'd0;
                    head_nxt_s    = '0;
                    k_nxt_s       = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                // Wipe the sample history so a run never sees the previous one.
                data_en_s = 1'b1;
                data_we_s = 4'hf;
                data_a_s  = idx_to_addr(k_r);
                if (k_r == LAST_IDX) begin
                    k_nxt_s = '0;
                    if (data_length == 32'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s     = ST_WAIT_IN;
                        ss_tready_nxt_s = 1'b1;
                    end
                end else begin
                    k_nxt_s = k_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end

            ST_WAIT_IN: begin
                data_a_s  = idx_to_addr(head_r);
                data_di_s = ss_tdata;
                if (in_hs_s) begin
                    data_en_s       = 1'b1;
                    data_we_s       = 4'hf;
                    count_nxt_s     = count_inc_s;
                    acc_nxt_s       = '0;
                    k_nxt_s         = '0;
                    ss_tready_nxt_s = 1'b0;
                    state_nxt_s     = ST_MAC;
                    // tlast is advisory only: a mismatch is flagged, never acted on.
                    if (ss_tlast != (count_inc_s == data_length)) begin
                        len_err_nxt_s = 1'b1;
                    end else begin
                        len_err_nxt_s = len_err_r;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_IN;
                end
            end

            ST_MAC: begin
                // Step k issues reads for tap k / sample head-k; their data is
                // accumulated one step later, step Tape_Num only drains.
                if (k_r <= LAST_IDX) begin
                    tap_en_s  = 1'b1;
                    tap_a_s   = idx_to_addr(k_r);
                    data_en_s = 1'b1;
                    data_a_s  = idx_to_addr(circ_idx(head_r, k_r));
                end else begin
                    tap_en_s  = 1'b0;
                    data_en_s = 1'b0;
                end
                if (k_r != '0) begin
                    acc_nxt_s = acc_add_s;
                end else begin
                    acc_nxt_s = acc_r;
                end
                if (k_r == DRAIN_K) begin
                    k_nxt_s         = '0;
                    state_nxt_s     = ST_OUT;
                    sm_tvalid_nxt_s = 1'b1;
                    sm_tdata_nxt_s  = acc_add_s;
                    sm_tlast_nxt_s  = (count_r == data_length);
                end else begin
                    k_nxt_s = k_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end

            ST_OUT: begin
                if (sm_tready) begin
                    sm_tvalid_nxt_s = 1'b0;
                    sm_tdata_nxt_s  = '0;
                    sm_tlast_nxt_s  = 1'b0;
                    if (head_r == LAST_IDX) begin
                        head_nxt_s = '0;
                    end else begin
                        head_nxt_s = head_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                    if (sm_tlast_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s     = ST_WAIT_IN;
                        ss_tready_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end

            ST_DONE: begin
                ap_done_nxt_s = 1'b1;
                ap_idle_nxt_s = 1'b1;
                state_nxt_s   = ST_IDLE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, pointers, accumulator and registered outputs.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            k_r         <= '0;
            head_r      <= '0;
            count_r     <= 32'd0;
            acc_r       <= '0;
            ap_idle_r   <= 1'b1;
            ap_done_r   <= 1'b0;
            len_err_r   <= 1'b0;
            ss_tready_r <= 1'b0;
            sm_tvalid_r <= 1'b0;
            sm_tdata_r  <= '0;
            sm_tlast_r  <= 1'b0;
        end else begin
            k_r         <= k_nxt_s;
            head_r      <= head_nxt_s;
            count_r     <= count_nxt_s;
            acc_r       <= acc_nxt_s;
            ap_idle_r   <= ap_idle_nxt_s;
            ap_done_r   <= ap_done_nxt_s;
            len_err_r   <= len_err_nxt_s;
            ss_tready_r <= ss_tready_nxt_s;
            sm_tvalid_r <= sm_tvalid_nxt_s;
            sm_tdata_r  <= sm_tdata_nxt_s;
            sm_tlast_r  <= sm_tlast_nxt_s;
        end
    end

    assign ap_idle   = ap_idle_r;
    assign ap_done   = ap_done_r;
    assign len_err   = len_err_r;
    assign ss_tready = ss_tready_r;
    assign sm_tvalid = sm_tvalid_r;
    assign sm_tdata  = sm_tdata_r;
    assign sm_tlast  = sm_tlast_r;
    assign tap_EN    = tap_en_s;
    assign tap_A     = tap_a_s;
    assign data_WE   = data_we_s;
    assign data_EN   = data_en_s;
    assign data_A    = data_a_s;
    assign data_Di   = data_di_s;

endmodule

// File: tb/tb_fir_engine_ctrl.sv
// Directed bench for fir_engine_ctrl with behavioural tap/data BRAMs, a
// reference FIR model and an expected-result queue.

module tb_fir_engine_ctrl;

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic        ap_start;
    logic [31:0] data_length;
    logic        ap_idle, ap_done, len_err;
    logic        ss_tvalid, ss_tready, ss_tlast;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] sm_tdata;
    logic        tap_EN;
    logic [11:0] tap_A;
    logic [31:0] tap_Do;
    logic [3:0]  data_WE;
    logic        data_EN;
    logic [11:0] data_A;
    logic [31:0] data_Di, data_Do;

    logic [31:0] tap_mem  [0:15];
    logic [31:0] data_mem [0:15];
    logic [31:0] hist [$];
    logic [32:0] exp_q [$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    int first_valid_cyc = -1;

    fir_engine_ctrl dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .ap_start(ap_start), .data_length(data_length),
        .ap_idle(ap_idle), .ap_done(ap_done), .len_err(len_err),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_WE(data_WE), .data_EN(data_EN), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) cyc <= cyc + 1;

    // Tap BRAM: 1-cycle read latency.
    always @(posedge axis_clk) begin
        if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];
    end

    // Data BRAM: 1-cycle read latency, write-first.
    always @(posedge axis_clk) begin
        if (data_EN) begin
            if (data_WE == 4'hf) begin
                data_mem[data_A[5:2]] <= data_Di;
                data_Do <= data_Di;
            end else begin
                data_Do <= data_mem[data_A[5:2]];
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    // Reference FIR: y[n] = sum tap[k]*x[n-k], history before the run is zero.
    function automatic logic [31:0] fir_model(input int n);
        logic [31:0] acc;
        acc = 32'd0;
        for (int k = 0; k < 11; k++) begin
            if (n - k >= 0) acc = acc + tap_mem[k] * hist[n - k];
        end
        return acc;
    endfunction

    task automatic start_run(input logic [31:0] len);
        data_length = len;
        hist.delete();
        exp_q.delete();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        chk("busy_ap_idle", ap_idle, 0);
        chk("busy_ap_done", ap_done, 0);
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        for (int t = 0; t < 100 && ss_tready !== 1'b1; t++) tick();
        chk("ss_tready_wait", ss_tready, 1);
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = last;
        hist.push_back(d);
        exp_q.push_back({(hist.size() == data_length), fir_model(hist.size() - 1)});
        tick();
        hs_cyc    = cyc;
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        ss_tdata  = 32'd0;
    endtask

    task automatic recv(input bit stall);
        bit got;
        logic [32:0] e;
        got = 1'b0;
        first_valid_cyc = -1;
        for (int t = 0; t < 300 && !got; t++) begin
            sm_tready = stall ? ((cyc % 3) == 0) : 1'b1;
            if (sm_tvalid === 1'b1 && exp_q.size() > 0) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                e = exp_q[0];
                chk("sm_tdata", sm_tdata, e[31:0]);
                if (sm_tready) begin
                    chk("sm_tlast", sm_tlast, e[32]);
                    exp_q.pop_front();
                    got = 1'b1;
                end
            end
            tick();
        end
        sm_tready = 1'b0;
        chk("sm_beat_seen", got, 1);
        chk("sm_tvalid_drop", sm_tvalid, 0);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 50 && ap_done !== 1'b1; t++) tick();
        chk("ap_done", ap_done, 1);
        chk("ap_idle", ap_idle, 1);
    endtask

    task automatic load_main_taps();
        tap_mem[0] = 32'd0;   tap_mem[1] = -32'sd10; tap_mem[2] = -32'sd9;
        tap_mem[3] = 32'd23;  tap_mem[4] = 32'd56;   tap_mem[5] = 32'd63;
        tap_mem[6] = 32'd56;  tap_mem[7] = 32'd23;   tap_mem[8] = -32'sd9;
        tap_mem[9] = -32'sd10; tap_mem[10] = 32'd0;
    endtask

    task automatic load_single_tap(input logic [31:0] t0);
        tap_mem[0] = t0;
        for (int i = 1; i < 16; i++) tap_mem[i] = 32'd0;
    endtask

    initial begin
        bit seen_ss, seen_sm;
        int p;
        logic [31:0] v;

        axis_rst = 1'b1; ap_start = 1'b0; data_length = 32'd0;
        ss_tvalid = 1'b0; ss_tdata = 32'd0; ss_tlast = 1'b0; sm_tready = 1'b0;
        for (int i = 0; i < 16; i++) tap_mem[i] = 32'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_ap_idle", ap_idle, 1);
        chk("rst_ap_done", ap_done, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_ss_tready", ss_tready, 0);
        chk("rst_sm_tvalid", sm_tvalid, 0);
        chk("rst_sm_tdata", sm_tdata, 0);
        chk("rst_sm_tlast", sm_tlast, 0);
        chk("rst_tap_EN", tap_EN, 0);
        chk("rst_data_EN", data_EN, 0);
        chk("rst_data_WE", data_WE, 0);
        chk("rst_data_A", data_A, 0);
        axis_rst = 1'b0;
        tick();

        // Impulse response: output equals the tap set
        load_main_taps();
        start_run(32'd11);
        for (int i = 0; i < 11; i++) begin
            send((i == 0) ? 32'd1 : 32'd0, i == 10);
            recv(1'b0);
            if (i == 0) chk("latency_12_13", ((first_valid_cyc - hs_cyc) >= 12) && ((first_valid_cyc - hs_cyc) <= 13), 1);
        end
        wait_done();
        chk("impulse_len_err", len_err, 0);

        // 600-sample triangle wave with output back-pressure
        start_run(32'd600);
        for (int i = 0; i < 600; i++) begin
            p = i % 40;
            v = (p < 20) ? 32'(p * 37 - 300) : 32'((40 - p) * 37 - 300);
            send(v, i == 599);
            recv(1'b1);
        end
        wait_done();
        chk("tri_len_err", len_err, 0);

        // Back-to-back runs
        start_run(32'd3);
        send(32'd7, 1'b0); recv(1'b0);
        send(32'd8, 1'b0); recv(1'b0);
        send(32'd9, 1'b1); recv(1'b0);
        wait_done();
        load_single_tap(32'd1);
        start_run(32'd3);
        for (int i = 0; i < 3; i++) begin
            send(32'd5, i == 2);
            recv(1'b0);
        end
        wait_done();

        // Zero-length run
        seen_ss = 1'b0; seen_sm = 1'b0;
        start_run(32'd0);
        for (int t = 0; t < 20; t++) begin
            if (ss_tready === 1'b1) seen_ss = 1'b1;
            if (sm_tvalid === 1'b1) seen_sm = 1'b1;
            tick();
        end
        chk("len0_ap_done", ap_done, 1);
        chk("len0_ss_tready_seen", seen_ss, 0);
        chk("len0_sm_tvalid_seen", seen_sm, 0);

        // Product wrap and early tlast
        load_single_tap(32'd4);
        start_run(32'd3);
        send(32'h4000_0000, 1'b0); recv(1'b0);
        send(32'd1, 1'b1);         recv(1'b0);
        chk("early_tlast_len_err", len_err, 1);
        send(32'd2, 1'b0);         recv(1'b0);
        wait_done();
        chk("wrap_len_err_sticky", len_err, 1);

        // Reset in the middle of a MAC pass
        load_main_taps();
        start_run(32'd11);
        for (int i = 0; i < 4; i++) begin
            send(32'(i * 3 + 1), 1'b0);
            recv(1'b0);
        end
        send(32'd13, 1'b0);
        repeat (4) tick();
        axis_rst = 1'b1;
        tick();
        chk("abort_ap_idle", ap_idle, 1);
        chk("abort_ap_done", ap_done, 0);
        chk("abort_sm_tvalid", sm_tvalid, 0);
        chk("abort_ss_tready", ss_tready, 0);
        chk("abort_tap_EN", tap_EN, 0);
        axis_rst = 1'b0;
        exp_q.delete();
        seen_sm = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (sm_tvalid === 1'b1) seen_sm = 1'b1;
            tick();
        end
        chk("abort_no_partial_beat", seen_sm, 0);
        start_run(32'd2);
        send(32'd100, 1'b0);    recv(1'b0);
        send(-32'sd50, 1'b1);   recv(1'b0);
        wait_done();
        chk("after_abort_len_err", len_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
